// File: rtl/posit_div_pkg.sv
// Shared posit32 (es=3) constants, FSM state encoding and the
// decoded-operand bundle used by the posit divider.
package posit_div_pkg;

    localparam int POSIT_N     = 32;
    localparam int POSIT_ES    = 3;
    localparam int USEED_SHIFT = 8;

    localparam logic [31:0] NAR    = 32'h8000_0000;
    localparam logic [31:0] MAXPOS = 32'h7FFF_FFFF;

    localparam int FRAC_W  = 26;
    localparam int MANT_W  = FRAC_W + 1;
    localparam int QUOT_W  = 34;
    localparam int SCALE_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        DIVIDE,
        NORM,
        ENCODE
    } state_t;

    typedef struct packed {
        logic                      sign;
        logic signed [SCALE_W-1:0] scale;
        logic [FRAC_W-1:0]         frac;
    } dec_t;

endpackage

// File: rtl/mant_divider.sv
// Restoring mantissa divider: one quotient bit per run cycle.
// Ports: load (capture operands), run (iterate), last (34th step),
// quot (1 integer + 33 fraction bits), sticky (remainder != 0).
module mant_divider
    import posit_div_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              run,
    input  logic [MANT_W-1:0] dividend,
    input  logic [MANT_W-1:0] divisor,
    output logic              last,
    output logic [QUOT_W-1:0] quot,
    output logic              sticky
);

    logic [MANT_W:0]   rem_q;
    logic [MANT_W-1:0] dvs_q;
    logic [QUOT_W-1:0] q_q;
    logic [5:0]        cnt_q;

    logic [MANT_W:0] diff;
    logic [MANT_W:0] nrem;
    logic            ge;

    // Remainder stays below twice the divisor, so one extra bit holds it.
    always_comb begin
        ge   = rem_q >= {1'b0, dvs_q};
        diff = rem_q - {1'b0, dvs_q};
        nrem = ge ? diff : rem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            dvs_q <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= {1'b0, dividend};
            dvs_q <= divisor;
            q_q   <= '0;
            cnt_q <= '0;
        end else if (run) begin
            rem_q <= nrem << 1;
            q_q   <= {q_q[QUOT_W-2:0], ge};
            cnt_q <= cnt_q + 6'd1;
        end
    end

    assign last   = run && (cnt_q == 6'(QUOT_W - 1));
    assign quot   = q_q;
    assign sticky = |rem_q;

endmodule

// File: rtl/posit_div.sv
// Multi-cycle posit32 (es=3) divider: decode, restoring divide, normalize, encode.
// Ports: start/posit_a/posit_b request; result/nar/zero with done pulse; busy.
module posit_div
    import posit_div_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] posit_a,
    input  logic [N-1:0] posit_b,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         nar,
    output logic         zero
);

    localparam int PACK_W = 2 + ES + QUOT_W - 1 + 34;

    state_t state_q, state_d;

    logic [N-1:0]              a_q, b_q;
    logic                      sign_q;
    logic signed [SCALE_W-1:0] scale_q;
    logic [QUOT_W-2:0]         qn_q;
    logic                      sticky_q;

    dec_t da, db;
    logic spec_nar, special;

    logic              div_load, div_run, div_last, div_sticky;
    logic [QUOT_W-1:0] div_quot;

    logic signed [SCALE_W-1:0] ke;
    logic [SCALE_W-1:0]        shamt;
    logic [PACK_W-1:0]         tmp, shv;
    logic signed [PACK_W-1:0]  ts;
    logic [N-2:0]              body, mag;
    logic                      rbit;
    logic [N-1:0]              enc_res;

    // Regime is the run length of the leading bit after the sign,
    // counted on the magnitude; exponent and fraction follow the
    // terminating bit.
    function automatic dec_t decode(input logic [N-1:0] p);
        logic [N-2:0]              m, t;
        logic [5:0]                r;
        logic [N-4:0]              ef;
        logic signed [SCALE_W-1:0] k;
        dec_t                      d;
        m = p[N-1] ? (~p[N-2:0] + (N-1)'(1)) : p[N-2:0];
        t = m[N-2] ? ~m : m;
        r = 6'd31;
        for (int i = 0; i < N - 1; i++) begin
            if (t[i]) r = 6'(N - 2 - i);
        end
        if (m[N-2]) k = $signed({4'd0, r}) - 10'sd1;
        else        k = -$signed({4'd0, r});
        ef      = m[N-4:0] << (r - 6'd1);
        d.sign  = p[N-1];
        d.scale = (k <<< ES) + $signed({7'd0, ef[N-4 -: ES]});
        d.frac  = ef[FRAC_W-1:0];
        return d;
    endfunction

    assign da = decode(a_q);
    assign db = decode(b_q);

    assign spec_nar = (a_q == NAR) || (b_q == NAR) || (b_q == '0);
    assign special  = spec_nar || (a_q == '0);

    assign busy = (state_q != IDLE);

    mant_divider u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .run      (div_run),
        .dividend ({1'b1, da.frac}),
        .divisor  ({1'b1, db.frac}),
        .last     (div_last),
        .quot     (div_quot),
        .sticky   (div_sticky)
    );

    always_comb begin
        state_d  = state_q;
        div_load = 1'b0;
        div_run  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = DECODE;
            end
            DECODE: begin
                if (special) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DIVIDE;
                    div_load = 1'b1;
                end
            end
            DIVIDE: begin
                div_run = 1'b1;
                if (div_last) state_d = NORM;
            end
            NORM:    state_d = ENCODE;
            ENCODE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Regime is built by shifting a 2-bit seed: sign-filling "10"
    // gives k+1 ones then 0, zero-filling "01" gives -k zeros then 1.
    // Bits below the 31-bit body feed guard and sticky for RNE.
    always_comb begin
        ke    = scale_q >>> ES;
        shamt = ke[SCALE_W-1] ? ~ke : ke;
        tmp   = {(ke[SCALE_W-1] ? 2'b01 : 2'b10),
                 scale_q[ES-1:0], qn_q, 34'd0};
        ts    = $signed(tmp) >>> shamt;
        if (ke[SCALE_W-1]) shv = tmp >> shamt;
        else               shv = ts;
        body = shv[PACK_W-1 -: N-1];
        rbit = shv[PACK_W-N] &
               ((|shv[PACK_W-N-1:0]) | sticky_q | body[0]);
        mag  = body + {{(N-2){1'b0}}, rbit};
        if (ke >= 10'sd30)       mag = MAXPOS[N-2:0];
        else if (ke < -10'sd30)  mag = {{(N-2){1'b0}}, 1'b1};
        enc_res = sign_q ? -{1'b0, mag} : {1'b0, mag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            scale_q  <= '0;
            qn_q     <= '0;
            sticky_q <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
            nar      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q <= posit_a;
                        b_q <= posit_b;
                    end
                end
                DECODE: begin
                    sign_q  <= da.sign ^ db.sign;
                    scale_q <= $signed(da.scale) - $signed(db.scale);
                    if (special) begin
                        result <= spec_nar ? NAR : '0;
                        nar    <= spec_nar;
                        zero   <= !spec_nar;
                        done   <= 1'b1;
                    end
                end
                NORM: begin
                    sticky_q <= div_sticky;
                    if (div_quot[QUOT_W-1]) begin
                        qn_q <= div_quot[QUOT_W-2:0];
                    end else begin
                        qn_q    <= {div_quot[QUOT_W-3:0], 1'b0};
                        scale_q <= scale_q - 10'sd1;
                    end
                end
                ENCODE: begin
                    result <= enc_res;
                    nar    <= 1'b0;
                    zero   <= 1'b0;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_div.sv
// Directed self-checking bench for posit_div.
// Expected quotients are hand-derived posit32/es=3 encodings.
module tb_posit_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] posit_a = '0;
    logic [31:0] posit_b = '0;
    logic [31:0] result;
    logic        done, busy, nar, zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        n;
        logic        z;
        int          lat;
    } vec_t;

    posit_div #(.N(32), .ES(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .posit_a (posit_a),
        .posit_b (posit_b),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .nar     (nar),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    // Issues one request from just after a clock edge and waits
    // (bounded) for done; lat is counted from the start cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic n,
                         output logic z, output int lat);
        posit_a = a;
        posit_b = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        posit_a = $urandom;
        posit_b = $urandom;
        lat = 999;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i + 1;
                break;
            end
        end
        r = result;
        n = nar;
        z = zero;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({result, done, busy, nar, zero} !== 36'd0) begin
            errors++;
            $display("FAIL reset_state got %h/%b%b%b%b want 0",
                     result, done, busy, nar, zero);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle got done=%b busy=%b want 0 0",
                     done, busy);
        end
    endtask

    task automatic test_normal;
        vec_t        v[6];
        logic [31:0] r;
        logic        n, z;
        int          lat;
        v[0] = '{32'h4000_0000, 32'h4400_0000, 32'h3C00_0000, 0, 0, 38};
        v[1] = '{32'h4600_0000, 32'h4400_0000, 32'h4200_0000, 0, 0, 38};
        v[2] = '{32'hC000_0000, 32'h4000_0000, 32'hC000_0000, 0, 0, 38};
        v[3] = '{32'hC000_0000, 32'hC000_0000, 32'h4000_0000, 0, 0, 38};
        v[4] = '{32'h4000_0000, 32'h4200_0000, 32'h3D55_5555, 0, 0, 38};
        v[5] = '{32'h6000_0000, 32'h3E00_0000, 32'h60AA_AAAB, 0, 0, 38};
        foreach (v[i]) begin
            do_op(v[i].a, v[i].b, r, n, z, lat);
            checks++;
            if ({r, n, z} !== {v[i].r, v[i].n, v[i].z}) begin
                errors++;
                $display("FAIL normal[%0d] %h/%h got %h n=%b z=%b want %h n=%b z=%b",
                         i, v[i].a, v[i].b, r, n, z, v[i].r, v[i].n, v[i].z);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++;
                $display("FAIL normal_lat[%0d] got %0d want %0d",
                         i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_special;
        vec_t        v[4];
        logic [31:0] r;
        logic        n, z;
        int          lat;
        v[0] = '{32'h4000_0000, 32'h0000_0000, 32'h8000_0000, 1, 0, 2};
        v[1] = '{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 0, 1, 2};
        v[2] = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1, 0, 2};
        v[3] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1, 0, 2};
        foreach (v[i]) begin
            do_op(v[i].a, v[i].b, r, n, z, lat);
            checks++;
            if ({r, n, z} !== {v[i].r, v[i].n, v[i].z}) begin
                errors++;
                $display("FAIL special[%0d] %h/%h got %h n=%b z=%b want %h n=%b z=%b",
                         i, v[i].a, v[i].b, r, n, z, v[i].r, v[i].n, v[i].z);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++;
                $display("FAIL special_lat[%0d] got %0d want %0d",
                         i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_saturate;
        vec_t        v[4];
        logic [31:0] r;
        logic        n, z;
        int          lat;
        v[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 0, 0, 38};
        v[1] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 38};
        v[2] = '{32'h8000_0001, 32'h0000_0001, 32'h8000_0001, 0, 0, 38};
        v[3] = '{32'h0000_0001, 32'h8000_0001, 32'hFFFF_FFFF, 0, 0, 38};
        foreach (v[i]) begin
            do_op(v[i].a, v[i].b, r, n, z, lat);
            checks++;
            if ({r, n, z} !== {v[i].r, v[i].n, v[i].z}) begin
                errors++;
                $display("FAIL saturate[%0d] %h/%h got %h n=%b z=%b want %h n=%b z=%b",
                         i, v[i].a, v[i].b, r, n, z, v[i].r, v[i].n, v[i].z);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++;
                $display("FAIL saturate_lat[%0d] got %0d want %0d",
                         i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        int extra;
        posit_a = 32'h4000_0000;
        posit_b = 32'h4400_0000;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 999;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_high got %b want 1", busy);
                end
            end
            if (done) begin
                lat = i + 1;
                break;
            end
            start   = (i == 3) || (i == 10) || (i == 20);
            posit_a = 32'h4600_0000;
            posit_b = 32'h7FFF_FFFF;
        end
        start = 1'b0;
        checks++;
        if (result !== 32'h3C00_0000) begin
            errors++;
            $display("FAIL busy_ignore got %h want 3c000000", result);
        end
        checks++;
        if (lat !== 38) begin
            errors++;
            $display("FAIL busy_lat got %0d want 38", lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_done_cycle got %b want 0", busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got %b want 0", done);
        end
        extra = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_extra_done got %0d want 0", extra);
        end
        checks++;
        if (result !== 32'h3C00_0000) begin
            errors++;
            $display("FAIL result_hold got %h want 3c000000", result);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        logic        n, z;
        int          lat;
        do_op(32'h4000_0000, 32'h4000_0000, r, n, z, lat);
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_done_cycle got busy=%b done=%b want 0 1",
                     busy, done);
        end
        do_op(32'h4600_0000, 32'h4400_0000, r, n, z, lat);
        checks++;
        if (r !== 32'h4200_0000) begin
            errors++;
            $display("FAIL b2b_result got %h want 42000000", r);
        end
        checks++;
        if (lat !== 38) begin
            errors++;
            $display("FAIL b2b_lat got %0d want 38", lat);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] r;
        logic        n, z;
        int          lat;
        int          extra;
        do_op(32'h4600_0000, 32'h4400_0000, r, n, z, lat);
        posit_a = 32'h4000_0000;
        posit_b = 32'h4400_0000;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({result, done, busy, nar, zero} !== 36'd0) begin
            errors++;
            $display("FAIL abort_clear got %h/%b%b%b%b want 0",
                     result, done, busy, nar, zero);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        extra = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d want 0", extra);
        end
        do_op(32'h4600_0000, 32'h4400_0000, r, n, z, lat);
        checks++;
        if (r !== 32'h4200_0000) begin
            errors++;
            $display("FAIL abort_fresh got %h want 42000000", r);
        end
        checks++;
        if (lat !== 38) begin
            errors++;
            $display("FAIL abort_fresh_lat got %0d want 38", lat);
        end
    endtask

    initial begin
        test_reset;
        test_normal;
        test_special;
        test_saturate;
        test_busy_ignore;
        test_back_to_back;
        test_reset_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
